// File: rtl/synth_pkg.sv
// Shared types for the synth voice control path:
// scheduler states and the queued note event.
package synth_pkg;

    localparam int EV_FCCW_W   = 30;
    localparam int ARM_TIMEOUT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIGGER,
        S_ARM,
        S_PLAYING,
        S_RELEASE
    } sched_state_t;

    typedef struct packed {
        logic                 note_on;
        logic [EV_FCCW_W-1:0] fccw;
    } note_ev_t;

endpackage

// File: rtl/note_scheduler_if.sv
// Note-event valid/ready channel into the scheduler.
interface note_scheduler_if #(
    parameter int PHASE_ACC_WIDTH = 30
);
    logic                       ev_valid;
    logic                       ev_ready;
    logic                       ev_note_on;
    logic [PHASE_ACC_WIDTH-1:0] ev_fccw;

    modport master (
        output ev_valid,
        output ev_note_on,
        output ev_fccw,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_note_on,
        input  ev_fccw,
        output ev_ready
    );
endinterface

// File: rtl/note_fifo.sv
// Small circular queue with a registered head word.
module note_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic             do_push;
    logic             do_pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_nxt  = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_nxt;
            if (do_push && !do_pop) level <= level + LW'(1);
            else if (!do_push && do_pop) level <= level - LW'(1);
            // Head tracks the oldest entry; a write into an empty queue lands here directly.
            if (do_pop) head <= (level == LW'(1)) ? push_data : mem[rd_nxt];
            else if (empty) head <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/note_scheduler.sv
// Queues note events and sequences oscillator pitch and ADSR start
// for self-timed and gate-held (real-time) envelopes.
module note_scheduler
    import synth_pkg::*;
#(
    parameter int PHASE_ACC_WIDTH = 30,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    note_scheduler_if.slave              ev,
    input  logic                         rt_mode,
    input  logic                         adsr_idle,
    output logic [PHASE_ACC_WIDTH-1:0]   osc_fccw,
    output logic                         adsr_start,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [7:0]                   drop_cnt
);
    sched_state_t               state, state_n;
    note_ev_t                   push_ev, head_ev;
    logic                       full, empty, pop;
    logic                       head_on, head_off;
    logic                       rt_q, rt_q_n;
    logic                       start_n;
    logic [PHASE_ACC_WIDTH-1:0] fccw_n;
    logic [PHASE_ACC_WIDTH-1:0] head_fccw;
    logic [7:0]                 drop_n;
    logic [2:0]                 arm_cnt, arm_cnt_n;

    assign ev.ev_ready     = reset && !full;
    assign push_ev.note_on = ev.ev_note_on;
    assign push_ev.fccw    = EV_FCCW_W'(ev.ev_fccw);

    note_fifo #(
        .WIDTH ($bits(note_ev_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ev.ev_valid && ev.ev_ready),
        .push_data (push_ev),
        .pop       (pop),
        .head      (head_ev),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign head_on   = !empty && head_ev.note_on;
    assign head_off  = !empty && !head_ev.note_on;
    assign head_fccw = PHASE_ACC_WIDTH'(head_ev.fccw);
    assign busy      = state != S_IDLE;

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        fccw_n    = osc_fccw;
        rt_q_n    = rt_q;
        start_n   = adsr_start;
        drop_n    = drop_cnt;
        arm_cnt_n = arm_cnt;
        unique case (state)
            S_IDLE: begin
                start_n = 1'b0;
                if (head_on) begin
                    pop     = 1'b1;
                    fccw_n  = head_fccw;
                    rt_q_n  = rt_mode;
                    state_n = S_TRIGGER;
                end else if (head_off) begin
                    pop = 1'b1;
                    if (drop_cnt != 8'hFF) drop_n = drop_cnt + 8'd1;
                end
            end
            S_TRIGGER: begin
                start_n   = 1'b1;
                arm_cnt_n = '0;
                state_n   = S_ARM;
            end
            S_ARM: begin
                // Self-timed envelopes only need a single-cycle start strobe.
                if (!rt_q) start_n = 1'b0;
                if (!adsr_idle) begin
                    state_n = S_PLAYING;
                end else if (arm_cnt == 3'(ARM_TIMEOUT - 1)) begin
                    state_n = S_IDLE;
                    start_n = 1'b0;
                end else begin
                    arm_cnt_n = arm_cnt + 3'd1;
                end
            end
            S_PLAYING: begin
                if (!rt_q) begin
                    if (adsr_idle) state_n = S_IDLE;
                end else if (head_on) begin
                    pop    = 1'b1;
                    fccw_n = head_fccw;
                end else if (head_off) begin
                    pop     = 1'b1;
                    start_n = 1'b0;
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (head_on) begin
                    pop     = 1'b1;
                    fccw_n  = head_fccw;
                    rt_q_n  = rt_mode;
                    state_n = S_TRIGGER;
                end else if (adsr_idle) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            osc_fccw   <= '0;
            rt_q       <= 1'b0;
            adsr_start <= 1'b0;
            drop_cnt   <= '0;
            arm_cnt    <= '0;
        end else begin
            state      <= state_n;
            osc_fccw   <= fccw_n;
            rt_q       <= rt_q_n;
            adsr_start <= start_n;
            drop_cnt   <= drop_n;
            arm_cnt    <= arm_cnt_n;
        end
    end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter PHASE_ACC_WIDTH, default 30, SHALL set the oscillator frequency-word width.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2, SHALL set the note-event queue depth.
REQ-003 clk  in  1  system clock; the block SHALL use this single clock.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 ev_valid  in  1  note event offered.
REQ-006 ev_ready  out  1  event accepted this cycle when high with ev_valid.
REQ-007 ev_note_on  in  1  1 = note-on, 0 = note-off.
REQ-008 ev_fccw  in  PHASE_ACC_WIDTH  pitch word for note-on; ignored for note-off.
REQ-009 rt_mode  in  1  1 = real-time (gate-held) ADSR; 0 = self-timed ADSR.
REQ-010 adsr_idle  in  1  combined envelope-idle status from the ADSR units.
REQ-011 osc_fccw  out  PHASE_ACC_WIDTH  registered pitch word to the oscillators.
REQ-012 adsr_start  out  1  envelope start, driven to the amplifier and filter ADSR units.
REQ-013 busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-015 drop_cnt  out  8  saturating count of discarded note-off events.

Function
REQ-016 Push SHALL occur when ev_valid && ev_ready; ev_ready SHALL be !full; an event offered while full SHALL be held off, not lost.
REQ-017 Pop SHALL occur only in the FSM cycles named below; a push and pop in the same cycle SHALL leave fifo_level unchanged.
REQ-018 FSM states SHALL be IDLE, TRIGGER, ARM, PLAYING, RELEASE.
REQ-019 IDLE, head note-on: pop, load osc_fccw <= head fccw, latch rt_q <= rt_mode, go to TRIGGER.
REQ-020 IDLE, head note-off: pop, increment drop_cnt (saturate at 255), stay in IDLE.
REQ-021 TRIGGER: adsr_start SHALL rise one cycle after entry; go to ARM next cycle.
REQ-022 In non-RT (rt_q=0), adsr_start SHALL be high for exactly one cycle; in RT (rt_q=1), it SHALL stay high until the note-off handling in REQ-025.
REQ-023 ARM: wait for adsr_idle=0, then go to PLAYING; if adsr_idle stays 1 for 8 consecutive cycles, return to IDLE with adsr_start low.
REQ-024 PLAYING, non-RT: the queue SHALL NOT be popped; on adsr_idle=1, go to IDLE.
REQ-025 PLAYING, RT: on head note-on (legato), pop and update osc_fccw without retrigger; on head note-off, pop, drop adsr_start next cycle, go to RELEASE.
REQ-026 RELEASE: on head note-on, pop, load osc_fccw, re-latch rt_q, go to TRIGGER; otherwise go to IDLE when adsr_idle=1.
REQ-027 osc_fccw SHALL change only on a note-on pop and SHALL otherwise hold its value.
REQ-028 A change of rt_mode mid-note SHALL have no effect until the next note-on pop.
REQ-029 Events SHALL be processed strictly in FIFO order; at most one pop per cycle.

Reset
REQ-030 While reset=0 at a clk edge: queue empty, fifo_level=0, state=IDLE, osc_fccw=0, adsr_start=0, busy=0, drop_cnt=0, rt_q=0.
REQ-031 ev_ready SHALL be 0 while reset is asserted and 1 in the first cycle after release.
REQ-032 Reset asserted mid-note SHALL drop adsr_start at that same edge and discard queued events.

Structure
REQ-033 The FSM state enum and the packed note-event struct {note_on, fccw} SHALL reside in the shared package synth_pkg.
REQ-034 The queue SHALL be a separate sub-module note_fifo (parameterised width/depth, registered head output, full/empty/level).
REQ-035 The block SHALL be instantiated in front of synth_module, replacing the host-driven oscillator-1 pitch word and both ADSR start inputs.

Verification
REQ-036 Non-RT: push on(fccw=0x0123456); model adsr_idle low 3 cycles after start, then high after 50 cycles -> osc_fccw=0x0123456, adsr_start is a one-cycle pulse, busy falls after idle returns.
REQ-037 RT legato: push on(0x100), then on(0x200), then off -> adsr_start held high through both notes, osc_fccw goes 0x100 then 0x200, a single start edge, adsr_start falls after the off is popped.
REQ-038 RT retrigger in RELEASE: on(0x100), off, on(0x300) while adsr_idle=0 -> adsr_start re-rises, osc_fccw=0x300.
REQ-039 Full queue: hold the FSM in PLAYING (non-RT) and push 5 events -> ev_ready=0 on the 5th, fifo_level=4, the 5th is accepted once a pop frees a slot.
REQ-040 Stray note-off in IDLE: push 3 offs -> drop_cnt=3 and no adsr_start; 300 offs -> drop_cnt=255.
REQ-041 Reset mid-note (RT, adsr_start high, 2 events queued) -> all outputs at REQ-030 values after the reset edge, fifo_level=0.
